// File: rtl/dm_sram_resp_if.sv
// CPU data-memory port: request fields from the CPU, combinational read data back.
interface dm_sram_resp_if;
  logic        DM_WEB;
  logic [31:0] DM_BWEB;
  logic [31:0] DM_addr;
  logic [31:0] DM_DI;
  logic [31:0] DM_DO;

  modport master (output DM_WEB, DM_BWEB, DM_addr, DM_DI, input DM_DO);
  modport slave  (input DM_WEB, DM_BWEB, DM_addr, DM_DI, output DM_DO);
endinterface

// File: rtl/dm_sram_resp.sv
// Data-memory responder: masked word array, one-entry posted write with
// store-to-load bypass, and an optional post-reset clear sweep.
module dm_sram_resp #(
  parameter int unsigned ADDR_W         = 14,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  dm_sram_resp_if.slave     dm,
  output logic              init_done,
  output logic              err_oob,
  output logic              err_busy,
  output logic [31:0]       wr_cnt
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned DW    = 32;

  typedef enum logic {ST_CLEAR, ST_READY} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_idx_q, clr_idx_d;
  logic                pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0]   pend_idx_q, pend_idx_d;
  logic [DW-1:0]       pend_data_q, pend_data_d;
  logic [DW-1:0]       pend_mask_q, pend_mask_d;
  logic                init_done_q, init_done_d;
  logic                err_oob_q, err_oob_d;
  logic                err_busy_q, err_busy_d;
  logic [DW-1:0]       wr_cnt_q, wr_cnt_d;

  logic [DW-1:0]       mem_q [DEPTH];
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_widx;
  logic [DW-1:0]       mem_wdata;

  logic [ADDR_W-1:0]   rd_idx;
  logic                oob;
  logic                is_wr;
  logic [DW-1:0]       rd_word;
  logic [DW-1:0]       dm_do_c;
  logic [1:0]          unused_addr_lsb;

  assign rd_idx          = dm.DM_addr[ADDR_W+1:2];
  assign oob             = |dm.DM_addr[31:ADDR_W+2];
  assign is_wr           = ~dm.DM_WEB;
  assign unused_addr_lsb = dm.DM_addr[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
      clr_idx_q    <= '0;
      pend_valid_q <= 1'b0;
      pend_idx_q   <= '0;
      pend_data_q  <= '0;
      pend_mask_q  <= '1;
      init_done_q  <= ~CLEAR_ON_RESET;
      err_oob_q    <= 1'b0;
      err_busy_q   <= 1'b0;
      wr_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
      pend_valid_q <= pend_valid_d;
      pend_idx_q   <= pend_idx_d;
      pend_data_q  <= pend_data_d;
      pend_mask_q  <= pend_mask_d;
      init_done_q  <= init_done_d;
      err_oob_q    <= err_oob_d;
      err_busy_q   <= err_busy_d;
      wr_cnt_q     <= wr_cnt_d;
    end
  end

  // Array has no reset; the single write port is held off while rst is high.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_widx] <= mem_wdata;
  end

  always_comb begin
    state_d      = state_q;
    clr_idx_d    = clr_idx_q;
    pend_valid_d = 1'b0;
    pend_idx_d   = pend_idx_q;
    pend_data_d  = pend_data_q;
    pend_mask_d  = pend_mask_q;
    init_done_d  = init_done_q;
    err_oob_d    = err_oob_q;
    err_busy_d   = err_busy_q;
    wr_cnt_d     = wr_cnt_q + DW'(pend_valid_q);
    mem_we       = 1'b0;
    mem_widx     = pend_idx_q;
    mem_wdata    = (mem_q[pend_idx_q] & pend_mask_q) | (pend_data_q & ~pend_mask_q);

    case (state_q)
      ST_CLEAR: begin
        mem_we    = ~rst;
        mem_widx  = clr_idx_q;
        mem_wdata = '0;
        clr_idx_d = clr_idx_q + ADDR_W'(1);
        if (clr_idx_q == {ADDR_W{1'b1}}) begin
          state_d     = ST_READY;
          init_done_d = 1'b1;
        end
        if (is_wr) err_busy_d = 1'b1;
      end
      ST_READY: begin
        mem_we = pend_valid_q & ~rst;
        if (oob) err_oob_d = 1'b1;
        if (is_wr && !oob) begin
          pend_valid_d = 1'b1;
          pend_idx_d   = rd_idx;
          pend_data_d  = dm.DM_DI;
          pend_mask_d  = dm.DM_BWEB;
        end
      end
      default: state_d = ST_READY;
    endcase
  end

  // Read data merges the still-pending write so a load right after a store sees it.
  always_comb begin
    rd_word = mem_q[rd_idx];
    dm_do_c = '0;
    if (state_q == ST_READY && !oob) begin
      if (pend_valid_q && pend_idx_q == rd_idx)
        dm_do_c = (rd_word & pend_mask_q) | (pend_data_q & ~pend_mask_q);
      else
        dm_do_c = rd_word;
    end
  end

  assign dm.DM_DO    = dm_do_c;
  assign init_done   = init_done_q;
  assign err_oob     = err_oob_q;
  assign err_busy    = err_busy_q;
  assign wr_cnt      = wr_cnt_q;

endmodule

// File: tb/tb_dm_sram_resp.sv
// Bench for dm_sram_resp (ADDR_W=4): scenario tasks plus randomized traffic
// checked against an architectural memory model where writes take effect at once.
module tb_dm_sram_resp;

  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;

  logic        clk;
  logic        rst;
  logic        init_done;
  logic        err_oob;
  logic        err_busy;
  logic [31:0] wr_cnt;

  dm_sram_resp_if dmif ();

  dm_sram_resp #(.ADDR_W(AW), .CLEAR_ON_RESET(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .dm        (dmif),
    .init_done (init_done),
    .err_oob   (err_oob),
    .err_busy  (err_busy),
    .wr_cnt    (wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Architectural view: every accepted write is visible immediately (bypass makes
  // this what the port shows); the counter lags acceptance by one edge.
  logic [31:0] arch_mem [DEPTH];
  bit          m_ready;
  int          m_clr_left;
  bit          m_oob;
  bit          m_busy;
  int unsigned m_accepted;
  bit          m_last_acc;
  logic [31:0] exp_do;
  logic [31:0] obs_do;

  function automatic logic [31:0] exp_wr_cnt();
    return 32'(m_accepted - 32'(m_last_acc));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) arch_mem[i] = 32'h0;
    m_ready    = 1'b0;
    m_clr_left = DEPTH;
    m_oob      = 1'b0;
    m_busy     = 1'b0;
    m_accepted = 0;
    m_last_acc = 1'b0;
  endtask

  // One clock: drive at posedge+1, sample DM_DO mid-cycle, advance model at the edge.
  task automatic cyc(input logic web, input logic [31:0] bweb,
                     input logic [31:0] addr, input logic [31:0] di);
    logic oob;
    int   idx;
    dmif.DM_WEB  = web;
    dmif.DM_BWEB = bweb;
    dmif.DM_addr = addr;
    dmif.DM_DI   = di;
    oob = (addr >> (AW + 2)) != 32'h0;
    idx = int'(addr[AW+1:2]);
    #3;
    exp_do = (m_ready && !oob) ? arch_mem[idx] : 32'h0;
    obs_do = dmif.DM_DO;
    @(posedge clk);
    m_last_acc = 1'b0;
    if (m_ready) begin
      if (oob) m_oob = 1'b1;
      if (!web && !oob) begin
        for (int b = 0; b < 32; b++)
          if (!bweb[b]) arch_mem[idx][b] = di[b];
        m_accepted++;
        m_last_acc = 1'b1;
      end
    end else begin
      if (!web) m_busy = 1'b1;
      m_clr_left--;
      if (m_clr_left == 0) m_ready = 1'b1;
    end
    #1;
  endtask

  task automatic rd(input logic [31:0] addr);
    cyc(1'b1, 32'hFFFF_FFFF, addr, 32'h0);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] di, input logic [31:0] bweb);
    cyc(1'b0, bweb, addr, di);
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b1;
    model_reset();
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset(2);
    checks++;
    if (init_done !== 1'b0 || err_oob !== 1'b0 || err_busy !== 1'b0 || wr_cnt !== 32'h0) begin
      failures++;
      $display("FAIL reset_state: init_done=%b err_oob=%b err_busy=%b wr_cnt=%0d want 0/0/0/0",
               init_done, err_oob, err_busy, wr_cnt);
    end
    for (int i = 0; i < DEPTH; i++) begin
      rd(32'(i * 4));
      checks++;
      if (obs_do !== 32'h0) begin
        failures++;
        $display("FAIL clear_do[%0d]: got %h want 00000000", i, obs_do);
      end
      checks++;
      if (init_done !== m_ready) begin
        failures++;
        $display("FAIL sweep_init_done[%0d]: got %b want %b", i, init_done, m_ready);
      end
    end
    checks++;
    if (init_done !== 1'b1) begin
      failures++;
      $display("FAIL init_done_final: got %b want 1", init_done);
    end
    for (int i = 0; i < DEPTH; i++) begin
      rd(32'(i * 4));
      checks++;
      if (obs_do !== 32'h0) begin
        failures++;
        $display("FAIL cleared_word[%0d]: got %h want 00000000", i, obs_do);
      end
    end
  endtask

  task automatic test_bypass();
    wr(32'h8, 32'hDEAD_BEEF, 32'h0);
    checks++;
    if (wr_cnt !== 32'h0) begin
      failures++;
      $display("FAIL bypass_cnt_early: got %0d want 0", wr_cnt);
    end
    rd(32'h8);
    checks++;
    if (obs_do !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL bypass_do: got %h want deadbeef", obs_do);
    end
    checks++;
    if (wr_cnt !== 32'h1) begin
      failures++;
      $display("FAIL bypass_cnt: got %0d want 1", wr_cnt);
    end
  endtask

  task automatic test_mask();
    wr(32'h8, 32'h1234_5678, 32'hFFFF_0000);
    rd(32'h8);
    checks++;
    if (obs_do !== 32'hDEAD_5678) begin
      failures++;
      $display("FAIL mask_bypass: got %h want dead5678", obs_do);
    end
    rd(32'h8);
    checks++;
    if (obs_do !== 32'hDEAD_5678) begin
      failures++;
      $display("FAIL mask_committed: got %h want dead5678", obs_do);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] base;
    base = wr_cnt;
    wr(32'h4, $urandom, 32'h0);
    wr(32'hC, $urandom, 32'h0);
    rd(32'h0);
    rd(32'h0);
    checks++;
    if (wr_cnt !== base + 32'd2) begin
      failures++;
      $display("FAIL b2b_cnt: got %0d want %0d", wr_cnt, base + 32'd2);
    end
    rd(32'h4);
    checks++;
    if (obs_do !== exp_do) begin
      failures++;
      $display("FAIL b2b_word4: got %h want %h", obs_do, exp_do);
    end
    rd(32'hC);
    checks++;
    if (obs_do !== exp_do) begin
      failures++;
      $display("FAIL b2b_wordC: got %h want %h", obs_do, exp_do);
    end
    // Same word twice: second mask lands over the first write's result.
    wr(32'h10, 32'hAAAA_AAAA, 32'h0000_FFFF);
    wr(32'h10, 32'h5555_5555, 32'hFF00_FF00);
    rd(32'h10);
    checks++;
    if (obs_do !== exp_do || obs_do !== 32'hAA55_0055 && exp_do === 32'hAA55_0055) begin
      failures++;
      $display("FAIL same_word_bypass: got %h want %h", obs_do, exp_do);
    end
    rd(32'h10);
    checks++;
    if (obs_do !== exp_do) begin
      failures++;
      $display("FAIL same_word_commit: got %h want %h", obs_do, exp_do);
    end
  endtask

  task automatic test_oob();
    logic [31:0] base;
    wr(32'h3F, 32'hCAFE_F00D, 32'h0);
    checks++;
    if (err_oob !== 1'b0) begin
      failures++;
      $display("FAIL oob_edge_inrange: got %b want 0", err_oob);
    end
    rd(32'h3C);
    checks++;
    if (obs_do !== 32'hCAFE_F00D) begin
      failures++;
      $display("FAIL lsb_ignored: got %h want cafef00d", obs_do);
    end
    base = wr_cnt;
    wr(32'h0000_1000, $urandom, 32'h0);
    checks++;
    if (err_oob !== 1'b1) begin
      failures++;
      $display("FAIL oob_flag: got %b want 1", err_oob);
    end
    rd(32'h0000_1000);
    checks++;
    if (obs_do !== 32'h0) begin
      failures++;
      $display("FAIL oob_read: got %h want 00000000", obs_do);
    end
    checks++;
    if (wr_cnt !== base) begin
      failures++;
      $display("FAIL oob_cnt: got %0d want %0d", wr_cnt, base);
    end
    rd(32'h0);
    checks++;
    if (obs_do !== exp_do) begin
      failures++;
      $display("FAIL oob_no_alias: got %h want %h", obs_do, exp_do);
    end
  endtask

  task automatic test_random();
    logic        web;
    logic [31:0] addr, bweb;
    for (int n = 0; n < 400; n++) begin
      web  = 1'($urandom_range(0, 1));
      addr = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 15) == 0) addr = addr | (32'h1 << $urandom_range(AW + 2, 31));
      case ($urandom_range(0, 5))
        0:       bweb = 32'hFFFF_FFFF;
        1:       bweb = 32'h0;
        default: bweb = $urandom;
      endcase
      cyc(web, bweb, addr, $urandom);
      checks++;
      if (obs_do !== exp_do) begin
        failures++;
        $display("FAIL rand_do[%0d]: addr=%h got %h want %h", n, addr, obs_do, exp_do);
      end
      checks++;
      if (wr_cnt !== exp_wr_cnt() || err_oob !== m_oob) begin
        failures++;
        $display("FAIL rand_status[%0d]: wr_cnt=%0d oob=%b want %0d %b",
                 n, wr_cnt, err_oob, exp_wr_cnt(), m_oob);
      end
    end
  endtask

  task automatic test_busy();
    int guard;
    apply_reset(2);
    rd(32'h0);
    rd(32'h0);
    wr(32'h4, 32'hAAAA_5555, 32'h0);
    checks++;
    if (err_busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_flag: got %b want 1", err_busy);
    end
    rd(32'h0000_1000);
    checks++;
    if (err_oob !== 1'b0) begin
      failures++;
      $display("FAIL oob_during_clear: got %b want 0", err_oob);
    end
    guard = 0;
    while (init_done !== 1'b1 && guard < 40) begin
      rd(32'h0);
      guard++;
    end
    checks++;
    if (init_done !== 1'b1 || m_ready !== 1'b1) begin
      failures++;
      $display("FAIL busy_init_timeout: init_done=%b model_ready=%b", init_done, m_ready);
    end
    rd(32'h4);
    checks++;
    if (obs_do !== 32'h0 || wr_cnt !== 32'h0) begin
      failures++;
      $display("FAIL busy_dropped: word=%h wr_cnt=%0d want 00000000 0", obs_do, wr_cnt);
    end
  endtask

  task automatic test_reset_pending();
    wr(32'h8, 32'h1357_9BDF, 32'h0);
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (wr_cnt !== 32'h0 || init_done !== 1'b0) begin
      failures++;
      $display("FAIL rst_pend_async: wr_cnt=%0d init_done=%b want 0 0", wr_cnt, init_done);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rd(32'h8);
      checks++;
      if (init_done !== m_ready || wr_cnt !== 32'h0 || obs_do !== 32'h0) begin
        failures++;
        $display("FAIL rst_pend_sweep[%0d]: init_done=%b wr_cnt=%0d do=%h want %b 0 0",
                 i, init_done, wr_cnt, obs_do, m_ready);
      end
    end
    rd(32'h8);
    checks++;
    if (obs_do !== 32'h0 || wr_cnt !== 32'h0) begin
      failures++;
      $display("FAIL rst_pend_discard: word=%h wr_cnt=%0d want 00000000 0", obs_do, wr_cnt);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    dmif.DM_WEB  = 1'b1;
    dmif.DM_BWEB = 32'hFFFF_FFFF;
    dmif.DM_addr = 32'h0;
    dmif.DM_DI   = 32'h0;
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_bypass();
    test_mask();
    test_back_to_back();
    test_oob();
    test_random();
    test_busy();
    test_reset_pending();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
